// File: rtl/tff_reg_arbiter_if.sv
// Bus between requesters and the shared T-flop register arbiter.
// q_par exists only when TFF_PARITY_EN is defined.
interface tff_reg_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic                  done;
  logic                  busy;
  logic [WIDTH-1:0]      q;
`ifdef TFF_PARITY_EN
  logic                  q_par;
`endif

  modport master (
`ifdef TFF_PARITY_EN
    input  q_par,
`endif
    output req, op, data,
    input  gnt, done, busy, q
  );

  modport slave (
`ifdef TFF_PARITY_EN
    output q_par,
`endif
    input  req, op, data,
    output gnt, done, busy, q
  );
endinterface

// File: rtl/tff_reg_arbiter.sv
// Round-robin arbitrated command sequencer over a WIDTH-bit register built from T flip-flops.
// Optional registered parity output enabled by defining TFF_PARITY_EN.
module tff_reg_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic              clk,
  input  logic              reset,
  tff_reg_arbiter_if.slave  bus
);
  localparam int PW = $clog2(NREQ);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_TOGGLE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PW-1:0]    r_rr_ptr;
  logic [PW-1:0]    r_idx;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_q;
  logic [NREQ-1:0]  r_gnt;
  logic             r_done;

  logic             w_found;
  logic [PW-1:0]    w_sel;
  logic [PW:0]      w_sum;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] w_t;

  // Search rr_ptr, rr_ptr+1, ... modulo NREQ for the first pending requester.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ))
        w_sum = w_sum - (PW+1)'(NREQ);
      if (!w_found && bus.req[w_sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[PW-1:0];
      end
    end
  end

  always_comb begin
    w_op   = OP_NOP;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_sel == PW'(i)) begin
        w_op   = bus.op[2*i +: 2];
        w_data = bus.data[WIDTH*i +: WIDTH];
      end
    end
  end

  // LOAD becomes a T-flop write by toggling exactly the bits that differ from q.
  always_comb begin
    w_t = '0;
    case (r_op)
      OP_NOP:    w_t = '0;
      OP_LOAD:   w_t = r_data ^ r_q;
      OP_TOGGLE: w_t = r_data;
      OP_CLEAR:  w_t = r_q;
      default:   w_t = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_found) w_next = EXEC;
      EXEC:    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
      r_idx    <= '0;
      r_op     <= OP_NOP;
      r_data   <= '0;
      r_q      <= '0;
      r_gnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_op   <= w_op;
            r_data <= w_data;
            r_idx  <= w_sel;
            r_gnt  <= NREQ'(1) << w_sel;
          end
        end
        EXEC: begin
          r_q    <= r_q ^ w_t;
          r_gnt  <= '0;
          r_done <= 1'b1;
        end
        DONE: begin
          r_done   <= 1'b0;
          r_rr_ptr <= (r_idx == PW'(NREQ-1)) ? '0 : r_idx + PW'(1);
        end
        default: begin
          r_gnt  <= '0;
          r_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef TFF_PARITY_EN
  logic r_q_par;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_q_par <= 1'b0;
    else if (r_state == EXEC)
      r_q_par <= ^(r_q ^ w_t);
  end

  assign bus.q_par = r_q_par;
`endif

  assign bus.gnt  = r_gnt;
  assign bus.done = r_done;
  assign bus.busy = (r_state != IDLE);
  assign bus.q    = r_q;
endmodule

// File: tb/tb_tff_reg_arbiter.sv
// Directed self-checking bench for tff_reg_arbiter (WIDTH=8, NREQ=4).
// Expected values are hand-computed; parity checks appear when TFF_PARITY_EN is defined.
module tb_tff_reg_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  localparam logic [1:0] NOP    = 2'b00;
  localparam logic [1:0] LOAD   = 2'b01;
  localparam logic [1:0] TOGGLE = 2'b10;
  localparam logic [1:0] CLEAR  = 2'b11;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  tff_reg_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  tff_reg_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [2*NREQ-1:0] o,
                               input logic [WIDTH*NREQ-1:0] d);
    bus.req  = r;
    bus.op   = o;
    bus.data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One requester alone issues a command; op/data are scrambled after grant to prove latching.
  task automatic runCmd(input int idx, input logic [1:0] opc, input logic [7:0] d,
                        input logic [7:0] expQ, input string tag);
    logic [NREQ-1:0]       r;
    logic [2*NREQ-1:0]     o;
    logic [WIDTH*NREQ-1:0] dv;
    r  = '0;
    o  = '0;
    dv = '0;
    r[idx]             = 1'b1;
    o[2*idx +: 2]      = opc;
    dv[WIDTH*idx +: 8] = d;
    applyStimulus(r, o, dv);
    tick();
    checkOutput({tag, "-gnt"}, 32'(bus.gnt), 32'(r));
    checkOutput({tag, "-busyExec"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, "-doneExec"}, 32'(bus.done), 32'd0);
    applyStimulus('0, ~o, ~dv);
    tick();
    checkOutput({tag, "-gntDone"}, 32'(bus.gnt), 32'd0);
    checkOutput({tag, "-done"}, 32'(bus.done), 32'd1);
    checkOutput({tag, "-q"}, 32'(bus.q), 32'(expQ));
    checkOutput({tag, "-busyDone"}, 32'(bus.busy), 32'd1);
`ifdef TFF_PARITY_EN
    checkOutput({tag, "-qpar"}, 32'(bus.q_par), 32'(^expQ));
`endif
    tick();
    checkOutput({tag, "-doneIdle"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "-busyIdle"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "-qIdle"}, 32'(bus.q), 32'(expQ));
  endtask

  initial begin
    int                order [4];
    logic [7:0]        orderQ [4];
    logic [NREQ-1:0]   pending;
    logic [NREQ-1:0]   oneHot;

    applyStimulus('0, '0, '0);

    // Asynchronous reset with no clock edge
    #3 reset = 1'b0;
    #1;
    checkOutput("rst-q", 32'(bus.q), 32'h00);
    checkOutput("rst-gnt", 32'(bus.gnt), 32'h0);
    checkOutput("rst-done", 32'(bus.done), 32'd0);
    checkOutput("rst-busy", 32'(bus.busy), 32'd0);
`ifdef TFF_PARITY_EN
    checkOutput("rst-qpar", 32'(bus.q_par), 32'd0);
`endif
    tick();
    tick();
    reset = 1'b1;

    runCmd(0, LOAD, 8'hA5, 8'hA5, "load0");
    runCmd(1, TOGGLE, 8'h0F, 8'hAA, "toggle1");
    runCmd(2, NOP, 8'h55, 8'hAA, "nop2");
    runCmd(1, LOAD, 8'h3C, 8'h3C, "load1");

    // All four requesting from rr_ptr=2; masks XOR back to 3C
    order  = '{2, 3, 0, 1};
    orderQ = '{8'h3D, 8'h3F, 8'h3B, 8'h3C};
    pending = 4'b1111;
    applyStimulus(pending, 8'hAA, {8'h02, 8'h01, 8'h07, 8'h04});
    for (int k = 0; k < 4; k++) begin
      tick();
      oneHot = '0;
      oneHot[order[k]] = 1'b1;
      checkOutput($sformatf("rr%0d-gnt", k), 32'(bus.gnt), 32'(oneHot));
      checkOutput($sformatf("rr%0d-doneExec", k), 32'(bus.done), 32'd0);
      pending[order[k]] = 1'b0;
      bus.req = pending;
      tick();
      checkOutput($sformatf("rr%0d-done", k), 32'(bus.done), 32'd1);
      checkOutput($sformatf("rr%0d-q", k), 32'(bus.q), 32'(orderQ[k]));
      tick();
      checkOutput($sformatf("rr%0d-doneIdle", k), 32'(bus.done), 32'd0);
    end

`ifdef TFF_PARITY_EN
    checkOutput("clr-qparBefore", 32'(bus.q_par), 32'd0);
`endif
    runCmd(3, CLEAR, 8'hC3, 8'h00, "clear3");
    runCmd(0, LOAD, 8'h01, 8'h01, "load01");

    // Reset while a LOAD FF sits in EXEC
    applyStimulus(4'b0100, 8'b00_01_00_00, {8'h00, 8'hFF, 8'h00, 8'h00});
    tick();
    checkOutput("abort-gnt", 32'(bus.gnt), 32'b0100);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort-q", 32'(bus.q), 32'h00);
    checkOutput("abort-gntOff", 32'(bus.gnt), 32'h0);
    checkOutput("abort-busy", 32'(bus.busy), 32'd0);
    checkOutput("abort-done", 32'(bus.done), 32'd0);
    applyStimulus(4'b1001, 8'b00_00_00_01, {8'h77, 8'h00, 8'h00, 8'h5A});
    tick();
    checkOutput("abort-noDone", 32'(bus.done), 32'd0);
    checkOutput("abort-qHeld", 32'(bus.q), 32'h00);
    reset = 1'b1;
    tick();
    checkOutput("post-gnt", 32'(bus.gnt), 32'b0001);
    applyStimulus('0, '0, '0);
    tick();
    checkOutput("post-done", 32'(bus.done), 32'd1);
    checkOutput("post-q", 32'(bus.q), 32'h5A);
    tick();
    checkOutput("post-doneIdle", 32'(bus.done), 32'd0);
    checkOutput("post-busyIdle", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
